// File: rtl/time_counter_bcd.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// time_counter_bcd
// BCD time-of-day counter for the alarm clock datapath. Keeps time internally
// in 24-hour BCD (hr 00-23, min 00-59, sec 00-59) and formats the outputs
// combinationally in either 24-hour or 12-hour + pm form.
//
// Parameters
//   SECONDS_EN  1: seconds digits present, tick advances seconds
//               0: tick advances minutes, seconds held at zero
//
// Ports
//   clk                       system clock, rising edge
//   reset                     asynchronous active-low reset -> 00:00:00
//   tick                      count enable, one increment per sampled edge
//   mode_24                   1 = 24 h format, 0 = 12 h format (outputs and load)
//   load_new_c                parallel load strobe
//   new_current_time_*        load value BCD digits (hours in mode_24 format)
//   new_pm                    load PM flag, 12 h format only
//   current_time_*            current time BCD digits in mode_24 format
//   pm                        internal hour >= 12
//   day_tick                  one-cycle pulse after 23:59:59 -> 00:00:00
//   load_err                  one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module time_counter_bcd #(
  parameter int SECONDS_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_24,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  input  logic [3:0] new_current_time_ms_sec,
  input  logic [3:0] new_current_time_ls_sec,
  input  logic       new_pm,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic [3:0] current_time_ms_sec,
  output logic [3:0] current_time_ls_sec,
  output logic       pm,
  output logic       day_tick,
  output logic       load_err
);

  localparam bit SEC_ON = (SECONDS_EN != 0);

  // Two BCD digits to binary. Accepts out-of-range digits (up to 15) so the
  // result is 8 bits wide and can be range-checked by the caller.
  function automatic logic [7:0] bcd2_to_bin(input logic [3:0] ms, input logic [3:0] ls);
    return ({4'd0, ms} * 8'd10) + {4'd0, ls};
  endfunction

  // Binary (0-99) to two BCD digits, packed {ms, ls}.
  function automatic logic [7:0] bin_to_bcd2(input logic [7:0] v);
    logic [3:0] ms;
    logic [3:0] ls;
    ms = 4'(v / 8'd10);
    ls = 4'(v % 8'd10);
    return {ms, ls};
  endfunction

  // Single digit increment with wrap at 'top', packed {carry, next}.
  function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic [3:0] top);
    if (d >= top) return {1'b1, 4'd0};
    else          return {1'b0, d + 4'd1};
  endfunction

  // Hour increment in 24 h BCD, packed {wrap, ms, ls}; wraps 23 -> 00.
  function automatic logic [8:0] hour_inc(input logic [3:0] ms, input logic [3:0] ls);
    if (ms >= 4'd2 && ls >= 4'd3) return {1'b1, 4'd0, 4'd0};
    else if (ls >= 4'd9)          return {1'b0, ms + 4'd1, 4'd0};
    else                          return {1'b0, ms, ls + 4'd1};
  endfunction

  // Internal 24 h hour to displayed hour: 0 -> 12, 13..23 -> 1..11.
  function automatic logic [7:0] hour_to_12h(input logic [7:0] h);
    if (h == 8'd0)      return 8'd12;
    else if (h > 8'd12) return h - 8'd12;
    else                return h;
  endfunction

  // 12 h load hour to 24 h: 12 AM -> 0, 12 PM -> 12, h PM -> h + 12.
  function automatic logic [7:0] hour_to_24h(input logic [7:0] h, input logic is_pm);
    if (h == 8'd12) return is_pm ? 8'd12 : 8'd0;
    else            return is_pm ? h + 8'd12 : h;
  endfunction

  logic [3:0] hr_ms_p0, hr_ls_p0, min_ms_p0, min_ls_p0, sec_ms_p0, sec_ls_p0;
  logic [3:0] hr_ms_nxt, hr_ls_nxt, min_ms_nxt, min_ls_nxt, sec_ms_nxt, sec_ls_nxt;
  logic       day_tick_nxt, load_err_nxt;

  // ---- load path: validate and convert the parallel load value ----
  logic [7:0] ld_hr_bin;
  logic [7:0] ld_hr24;
  logic [7:0] ld_hr_bcd;
  logic       ld_digits_ok;
  logic       ld_hour_ok;
  logic       ld_ok;

  assign ld_hr_bin = bcd2_to_bin(new_current_time_ms_hr, new_current_time_ls_hr);

  assign ld_digits_ok = (new_current_time_ms_hr  <= 4'd9) &&
                        (new_current_time_ls_hr  <= 4'd9) &&
                        (new_current_time_ms_min <= 4'd5) &&
                        (new_current_time_ls_min <= 4'd9) &&
                        (!SEC_ON || ((new_current_time_ms_sec <= 4'd5) &&
                                     (new_current_time_ls_sec <= 4'd9)));

  assign ld_hour_ok = mode_24 ? (ld_hr_bin <= 8'd23)
                              : ((ld_hr_bin >= 8'd1) && (ld_hr_bin <= 8'd12));

  assign ld_ok     = ld_digits_ok && ld_hour_ok;
  assign ld_hr24   = mode_24 ? ld_hr_bin : hour_to_24h(ld_hr_bin, new_pm);
  assign ld_hr_bcd = bin_to_bcd2(ld_hr24);

  // ---- count path: BCD carry chain ----
  logic [4:0] sec_ls_inc, sec_ms_inc, min_ls_inc, min_ms_inc;
  logic [8:0] hr_inc;
  logic       sec_carry;
  logic       min_carry;

  assign sec_ls_inc = digit_inc(sec_ls_p0, 4'd9);
  assign sec_ms_inc = digit_inc(sec_ms_p0, 4'd5);
  assign min_ls_inc = digit_inc(min_ls_p0, 4'd9);
  assign min_ms_inc = digit_inc(min_ms_p0, 4'd5);
  assign hr_inc     = hour_inc(hr_ms_p0, hr_ls_p0);

  // Without seconds every tick is a whole minute.
  assign sec_carry = SEC_ON ? (sec_ls_inc[4] & sec_ms_inc[4]) : 1'b1;
  assign min_carry = min_ls_inc[4] & min_ms_inc[4];

  // Load has priority over tick; a load never raises day_tick.
  always_comb begin
    hr_ms_nxt    = hr_ms_p0;
    hr_ls_nxt    = hr_ls_p0;
    min_ms_nxt   = min_ms_p0;
    min_ls_nxt   = min_ls_p0;
    sec_ms_nxt   = sec_ms_p0;
    sec_ls_nxt   = sec_ls_p0;
    day_tick_nxt = 1'b0;
    load_err_nxt = 1'b0;

    if (load_new_c) begin
      if (ld_ok) begin
        hr_ms_nxt  = ld_hr_bcd[7:4];
        hr_ls_nxt  = ld_hr_bcd[3:0];
        min_ms_nxt = new_current_time_ms_min;
        min_ls_nxt = new_current_time_ls_min;
        sec_ms_nxt = SEC_ON ? new_current_time_ms_sec : 4'd0;
        sec_ls_nxt = SEC_ON ? new_current_time_ls_sec : 4'd0;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (tick) begin
      if (SEC_ON) begin
        sec_ls_nxt = sec_ls_inc[3:0];
        if (sec_ls_inc[4]) sec_ms_nxt = sec_ms_inc[3:0];
      end
      if (sec_carry) begin
        min_ls_nxt = min_ls_inc[3:0];
        if (min_ls_inc[4]) min_ms_nxt = min_ms_inc[3:0];
        if (min_carry) begin
          hr_ms_nxt    = hr_inc[7:4];
          hr_ls_nxt    = hr_inc[3:0];
          day_tick_nxt = hr_inc[8];
        end
      end
    end

    // Seconds state is pinned to zero when the field is absent.
    if (!SEC_ON) begin
      sec_ms_nxt = 4'd0;
      sec_ls_nxt = 4'd0;
    end
  end

  // ---- state register stage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hr_ms_p0  <= 4'd0;
      hr_ls_p0  <= 4'd0;
      min_ms_p0 <= 4'd0;
      min_ls_p0 <= 4'd0;
      sec_ms_p0 <= 4'd0;
      sec_ls_p0 <= 4'd0;
      day_tick  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      hr_ms_p0  <= hr_ms_nxt;
      hr_ls_p0  <= hr_ls_nxt;
      min_ms_p0 <= min_ms_nxt;
      min_ls_p0 <= min_ls_nxt;
      sec_ms_p0 <= sec_ms_nxt;
      sec_ls_p0 <= sec_ls_nxt;
      day_tick  <= day_tick_nxt;
      load_err  <= load_err_nxt;
    end
  end

  // ---- output formatting: combinational view of the state ----
  logic [7:0] hr_bin;
  logic [7:0] hr12_bcd;

  assign hr_bin   = bcd2_to_bin(hr_ms_p0, hr_ls_p0);
  assign hr12_bcd = bin_to_bcd2(hour_to_12h(hr_bin));
  assign pm       = (hr_bin >= 8'd12);

  always_comb begin
    if (mode_24) begin
      current_time_ms_hr = hr_ms_p0;
      current_time_ls_hr = hr_ls_p0;
    end else begin
      current_time_ms_hr = hr12_bcd[7:4];
      current_time_ls_hr = hr12_bcd[3:0];
    end
  end

  assign current_time_ms_min = min_ms_p0;
  assign current_time_ls_min = min_ls_p0;
  assign current_time_ms_sec = sec_ms_p0;
  assign current_time_ls_sec = sec_ls_p0;

endmodule

// File: tb/tb_time_counter_bcd.sv
`timescale 1ns/1ps
module tb_time_counter_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick, mode_24, load_new_c, new_pm;
  logic [3:0] n_mh, n_lh, n_mm, n_lm, n_ms, n_ls;

  logic [3:0] a_mh, a_lh, a_mm, a_lm, a_ms, a_ls;
  logic       a_pm, a_dt, a_le;
  logic [3:0] b_mh, b_lh, b_mm, b_lm, b_ms, b_ls;
  logic       b_pm, b_dt, b_le;

  // Instance with seconds enabled
  time_counter_bcd #(.SECONDS_EN(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .mode_24(mode_24), .load_new_c(load_new_c),
    .new_current_time_ms_hr(n_mh), .new_current_time_ls_hr(n_lh),
    .new_current_time_ms_min(n_mm), .new_current_time_ls_min(n_lm),
    .new_current_time_ms_sec(n_ms), .new_current_time_ls_sec(n_ls),
    .new_pm(new_pm),
    .current_time_ms_hr(a_mh), .current_time_ls_hr(a_lh),
    .current_time_ms_min(a_mm), .current_time_ls_min(a_lm),
    .current_time_ms_sec(a_ms), .current_time_ls_sec(a_ls),
    .pm(a_pm), .day_tick(a_dt), .load_err(a_le)
  );

  // Instance without seconds, same stimulus
  time_counter_bcd #(.SECONDS_EN(0)) dut_nosec (
    .clk(clk), .reset(reset), .tick(tick), .mode_24(mode_24), .load_new_c(load_new_c),
    .new_current_time_ms_hr(n_mh), .new_current_time_ls_hr(n_lh),
    .new_current_time_ms_min(n_mm), .new_current_time_ls_min(n_lm),
    .new_current_time_ms_sec(n_ms), .new_current_time_ls_sec(n_ls),
    .new_pm(new_pm),
    .current_time_ms_hr(b_mh), .current_time_ls_hr(b_lh),
    .current_time_ms_min(b_mm), .current_time_ls_min(b_lm),
    .current_time_ms_sec(b_ms), .current_time_ls_sec(b_ls),
    .pm(b_pm), .day_tick(b_dt), .load_err(b_le)
  );

  logic [26:0] obs_a, obs_b;
  assign obs_a = {a_mh, a_lh, a_mm, a_lm, a_ms, a_ls, a_pm, a_dt, a_le};
  assign obs_b = {b_mh, b_lh, b_mm, b_lm, b_ms, b_ls, b_pm, b_dt, b_le};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: time as seconds of day, plus registered pulse flags
  int m_a, m_b;
  bit dt_a, dt_b, le_a, le_b;

  typedef struct {
    string       tag;
    logic [26:0] ea;
    logic [26:0] eb;
  } exp_t;
  exp_t sb[$];

  function automatic logic [26:0] view(input int t, input bit m24, input bit dt, input bit le);
    int h, mi, s, dh;
    h  = t / 3600;
    mi = (t / 60) % 60;
    s  = t % 60;
    dh = m24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    return {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            (h >= 12), dt, le};
  endfunction

  task automatic upd(inout int t, inout bit dt, inout bit le, input bit sec_en,
                     input bit tk, input bit ld);
    int h, mi, s;
    bit ok;
    dt = 0;
    le = 0;
    if (ld) begin
      h  = n_mh * 10 + n_lh;
      mi = n_mm * 10 + n_lm;
      s  = n_ms * 10 + n_ls;
      ok = (n_mh <= 9) && (n_lh <= 9) && (n_mm <= 5) && (n_lm <= 9) &&
           (!sec_en || ((n_ms <= 5) && (n_ls <= 9)));
      ok = ok && (mode_24 ? (h <= 23) : (h >= 1 && h <= 12));
      if (ok) begin
        if (!mode_24) h = (h == 12) ? (new_pm ? 12 : 0) : (new_pm ? h + 12 : h);
        t = h * 3600 + mi * 60 + (sec_en ? s : 0);
      end else begin
        le = 1;
      end
    end else if (tk) begin
      t = t + (sec_en ? 1 : 60);
      if (t >= 86400) begin
        t  = 0;
        dt = 1;
      end
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 27'd1, 27'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "/sec"}, obs_a, e.ea);
      check({e.tag, "/nosec"}, obs_b, e.eb);
    end
  endtask

  function automatic exp_t mk(input string tag);
    exp_t e;
    e.tag = tag;
    e.ea  = view(m_a, mode_24, dt_a, le_a);
    e.eb  = view(m_b, mode_24, dt_b, le_b);
    return e;
  endfunction

  // Called just after a falling edge; drives one clock of stimulus.
  task automatic cyc(input string tag, input bit tk, input bit ld);
    tick       = tk;
    load_new_c = ld;
    upd(m_a, dt_a, le_a, 1'b1, tk, ld);
    upd(m_b, dt_b, le_b, 1'b0, tk, ld);
    sb.push_back(mk(tag));
    @(posedge clk);
    #1;
    tick       = 1'b0;
    load_new_c = 1'b0;
    compare_head();
    @(negedge clk);
  endtask

  // Check the present combinational view without a clock edge.
  task automatic now_chk(input string tag);
    sb.push_back(mk(tag));
    #1;
    compare_head();
  endtask

  task automatic set_ld(input logic [3:0] mh, input logic [3:0] lh, input logic [3:0] mm,
                        input logic [3:0] lm, input logic [3:0] ms, input logic [3:0] ls,
                        input logic p);
    n_mh = mh; n_lh = lh; n_mm = mm; n_lm = lm; n_ms = ms; n_ls = ls; new_pm = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; tick = 1'b0; mode_24 = 1'b1; load_new_c = 1'b0;
    set_ld(0, 0, 0, 0, 0, 0, 0);
    m_a = 0; m_b = 0; dt_a = 0; dt_b = 0; le_a = 0; le_b = 0;
    now_chk("rst_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) cyc("count", 1, 0);

    // Asynchronous reset mid-count, both display modes
    #2;
    reset = 1'b0;
    m_a = 0; m_b = 0; dt_a = 0; dt_b = 0; le_a = 0; le_b = 0;
    now_chk("rst_async_24h");
    mode_24 = 1'b0;
    now_chk("rst_async_12h");
    @(negedge clk);
    reset = 1'b1;
    mode_24 = 1'b1;

    // Day rollover (no-seconds instance loads 23:59 and rolls on first tick)
    set_ld(2, 3, 5, 9, 5, 8, 0);
    cyc("ld_235958", 0, 1);
    cyc("roll_t1", 1, 0);
    cyc("roll_t2", 1, 0);
    cyc("roll_t3", 1, 0);

    // 12 h conversion
    mode_24 = 1'b0;
    set_ld(1, 1, 5, 9, 5, 9, 0);
    cyc("ld_115959am", 0, 1);
    cyc("noon_tick", 1, 0);
    mode_24 = 1'b1;
    now_chk("noon_24h_view");
    mode_24 = 1'b0;
    set_ld(1, 2, 3, 0, 0, 0, 0);
    cyc("ld_1230am", 0, 1);
    mode_24 = 1'b1;
    now_chk("1230am_24h_view");
    mode_24 = 1'b0;
    set_ld(0, 7, 4, 5, 1, 0, 1);
    cyc("ld_0745pm", 0, 1);
    mode_24 = 1'b1;
    now_chk("0745pm_24h_view");

    // Invalid loads, including back-to-back rejections
    set_ld(2, 4, 0, 0, 0, 0, 0);
    cyc("inv_hr24", 0, 1);
    set_ld(1, 0, 6, 0, 0, 0, 0);
    cyc("inv_min60", 0, 1);
    cyc("inv_clear", 0, 0);
    mode_24 = 1'b0;
    set_ld(0, 0, 1, 5, 0, 0, 0);
    cyc("inv_12h_00", 0, 1);
    mode_24 = 1'b1;
    set_ld(1, 0, 0, 0, 0, 4'hA, 0);
    cyc("inv_lssec10", 0, 1);
    set_ld(0, 9, 1, 6, 0, 0, 0);
    cyc("ld_091600", 0, 1);

    // Load/tick collision
    set_ld(1, 0, 0, 0, 0, 0, 0);
    cyc("ld_100000", 0, 1);
    set_ld(1, 8, 3, 2, 0, 0, 0);
    cyc("collide", 1, 1);
    cyc("after_collide", 1, 0);

    // Carry chain
    set_ld(0, 9, 5, 9, 5, 9, 0);
    cyc("ld_095959", 0, 1);
    cyc("carry_10", 1, 0);
    set_ld(1, 9, 5, 9, 5, 9, 0);
    cyc("ld_195959", 0, 1);
    cyc("carry_20", 1, 0);

    // Loading midnight must not raise day_tick
    set_ld(0, 0, 0, 0, 0, 0, 0);
    cyc("ld_midnight", 0, 1);

    // Random tick pattern across both modes
    for (int i = 0; i < 40; i++) begin
      mode_24 = 1'($urandom_range(0, 1));
      cyc("rand_tick", 1'($urandom_range(0, 1)), 0);
    end

    check("sb_drain", 27'(sb.size()), 27'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
